// File: rtl/inst_fetch_cache_pkg.sv
// Shared types and default geometry for the instruction fetch cache.
// Contents:
//   DEF_LINES / DEF_LINE_WORDS / DEF_ADDR_W : default cache geometry
//   WORD_W                                  : instruction word width
//   ic_state_e                              : refill FSM states
package inst_fetch_cache_pkg;

   localparam int unsigned DEF_LINES      = 16;
   localparam int unsigned DEF_LINE_WORDS = 4;
   localparam int unsigned DEF_ADDR_W     = 32;
   localparam int unsigned WORD_W         = 32;

   typedef enum logic {
      IcIdle   = 1'b0,
      IcRefill = 1'b1
   } ic_state_e;

endpackage

// File: rtl/icache_line_ram.sv
// Data and tag storage for the instruction cache: LINES x LINE_WORDS words plus one tag per line.
// Asynchronous read, synchronous write, no reset (validity is tracked by the parent).
// Ports:
//   clk        in   clock
//   rd_idx     in   line index for the read port
//   rd_off     in   word offset for the read port
//   rd_data    out  word at [rd_idx][rd_off]
//   rd_tag     out  tag stored for line rd_idx
//   wr_en      in   write wr_data to [wr_idx][wr_off]
//   wr_idx     in   line index for both write ports
//   wr_off     in   word offset for the data write
//   wr_data    in   data to write
//   tag_wr_en  in   write wr_tag to line wr_idx
//   wr_tag     in   tag to write
module icache_line_ram
   import inst_fetch_cache_pkg::*;
#(
   parameter int unsigned LINES      = DEF_LINES,
   parameter int unsigned LINE_WORDS = DEF_LINE_WORDS,
   parameter int unsigned TAG_W      = 26,
   parameter int unsigned IDX_W      = $clog2(LINES),
   parameter int unsigned OFF_W      = $clog2(LINE_WORDS)
) (
   input  logic              clk,
   input  logic [IDX_W-1:0]  rd_idx,
   input  logic [OFF_W-1:0]  rd_off,
   output logic [WORD_W-1:0] rd_data,
   output logic [TAG_W-1:0]  rd_tag,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [OFF_W-1:0]  wr_off,
   input  logic [WORD_W-1:0] wr_data,
   input  logic              tag_wr_en,
   input  logic [TAG_W-1:0]  wr_tag
);

   logic [WORD_W-1:0] data_arr [LINES][LINE_WORDS];
   logic [TAG_W-1:0]  tag_arr  [LINES];

   assign rd_data = data_arr[rd_idx][rd_off];
   assign rd_tag  = tag_arr[rd_idx];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         data_arr[wr_idx][wr_off] <= wr_data;
      end
      if (tag_wr_en) begin
         tag_arr[wr_idx] <= wr_tag;
      end
   end

endmodule

// File: rtl/inst_fetch_cache.sv
// Direct-mapped instruction cache between the core fetch port and a slow word-wide memory.
// Hits return data in the fetch cycle; a miss raises stall_req_o and the FSM refills the whole
// line as a burst from word 0 upward.
// Ports:
//   clk          in   clock
//   rst          in   asynchronous active-low reset
//   ce_i         in   fetch enable
//   addr_i       in   fetch byte address (bits[1:0] ignored)
//   data_o       out  instruction word (0 when not hit)
//   stall_req_o  out  fetch not served this cycle
//   flush_i      in   invalidate all lines
//   mem_req_o    out  external read request, high for the whole burst
//   mem_addr_o   out  word address of the requested word
//   mem_ack_i    in   external word valid
//   mem_data_i   in   external read data
module inst_fetch_cache
   import inst_fetch_cache_pkg::*;
#(
   parameter int unsigned LINES      = DEF_LINES,
   parameter int unsigned LINE_WORDS = DEF_LINE_WORDS,
   parameter int unsigned ADDR_W     = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ce_i,
   input  logic [ADDR_W-1:0] addr_i,
   output logic [WORD_W-1:0] data_o,
   output logic              stall_req_o,
   input  logic              flush_i,
   output logic              mem_req_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic              mem_ack_i,
   input  logic [WORD_W-1:0] mem_data_i
);

   localparam int unsigned OFF_W  = $clog2(LINE_WORDS);
   localparam int unsigned IDX_W  = $clog2(LINES);
   localparam int unsigned TAG_W  = ADDR_W - 2 - OFF_W - IDX_W;
   localparam int unsigned LINE_W = ADDR_W - 2 - OFF_W;  // line address = {tag, index}
   localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);

   logic [OFF_W-1:0]  offset;
   logic [IDX_W-1:0]  index;
   logic [TAG_W-1:0]  tag;
   logic [WORD_W-1:0] rd_data;
   logic [TAG_W-1:0]  rd_tag;
   logic              hit;
   logic              unused_addr;

   ic_state_e         state_q, state_d;
   logic [OFF_W-1:0]  cnt_q, cnt_d;
   logic [LINE_W-1:0] line_q, line_d;
   logic [LINES-1:0]  valid_q, valid_d;
   logic              flushed_q, flushed_d;
   logic              ram_we, tag_we;

   assign offset      = addr_i[2 +: OFF_W];
   assign index       = addr_i[2 + OFF_W +: IDX_W];
   assign tag         = addr_i[ADDR_W-1 -: TAG_W];
   assign unused_addr = ^addr_i[1:0];

   icache_line_ram #(
      .LINES      (LINES),
      .LINE_WORDS (LINE_WORDS),
      .TAG_W      (TAG_W),
      .IDX_W      (IDX_W),
      .OFF_W      (OFF_W)
   ) u_line_ram (
      .clk        (clk),
      .rd_idx     (index),
      .rd_off     (offset),
      .rd_data    (rd_data),
      .rd_tag     (rd_tag),
      .wr_en      (ram_we),
      .wr_idx     (line_q[IDX_W-1:0]),
      .wr_off     (cnt_q),
      .wr_data    (mem_data_i),
      .tag_wr_en  (tag_we),
      .wr_tag     (line_q[LINE_W-1 -: TAG_W])
   );

   assign hit         = ce_i & valid_q[index] & (rd_tag == tag);
   assign data_o      = hit ? rd_data : '0;
   assign stall_req_o = ce_i & ~hit;
   assign mem_req_o   = (state_q == IcRefill);
   assign mem_addr_o  = mem_req_o ? {line_q, cnt_q, 2'b00} : '0;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      line_d    = line_q;
      valid_d   = valid_q;
      flushed_d = flushed_q;
      ram_we    = 1'b0;
      tag_we    = 1'b0;
      case (state_q)
         IcIdle: begin
            if (ce_i && !hit) begin
               state_d        = IcRefill;
               line_d         = addr_i[ADDR_W-1 : 2 + OFF_W];
               cnt_d          = '0;
               flushed_d      = 1'b0;
               // The victim line is invalid while its words are overwritten.
               valid_d[index] = 1'b0;
            end
         end
         IcRefill: begin
            if (mem_ack_i) begin
               ram_we = 1'b1;
               cnt_d  = cnt_q + 1'b1;
               if (cnt_q == LAST_WORD) begin
                  tag_we  = 1'b1;
                  state_d = IcIdle;
                  // A flush seen anywhere in the burst leaves the refilled line invalid.
                  if (!flushed_q && !flush_i) begin
                     valid_d[line_q[IDX_W-1:0]] = 1'b1;
                  end
               end
            end
         end
         default: state_d = IcIdle;
      endcase
      if (flush_i) begin
         valid_d = '0;
         if (state_q == IcRefill) begin
            flushed_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IcIdle;
         cnt_q     <= '0;
         line_q    <= '0;
         valid_q   <= '0;
         flushed_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         line_q    <= line_d;
         valid_q   <= valid_d;
         flushed_q <= flushed_d;
      end
   end

endmodule

// File: tb/tb_inst_fetch_cache.sv
// Self-checking bench for inst_fetch_cache: directed scenarios followed by a randomized phase,
// all checked against a line-level cache model and a sparse external memory model.
module tb_inst_fetch_cache;

   logic        clk = 1'b0;
   logic        rst;
   logic        ce;
   logic [31:0] addr;
   logic [31:0] data;
   logic        stall;
   logic        flush;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_data;

   int n_cmp = 0;
   int n_err = 0;

   // Model state: 16 lines x 4 words, tag = addr >> 8.
   bit          m_valid [16];
   logic [31:0] m_tag   [16];
   logic [31:0] m_data  [16][4];
   logic [31:0] ext_mem [int unsigned];

   always #5 clk = ~clk;

   inst_fetch_cache dut (
      .clk         (clk),
      .rst         (rst),
      .ce_i        (ce),
      .addr_i      (addr),
      .data_o      (data),
      .stall_req_o (stall),
      .flush_i     (flush),
      .mem_req_o   (mem_req),
      .mem_addr_o  (mem_addr),
      .mem_ack_i   (mem_ack),
      .mem_data_i  (mem_data)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (!ext_mem.exists(a)) ext_mem[a] = $urandom;
      return ext_mem[a];
   endfunction

   task automatic model_flush();
      for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
   endtask

   // Check the current fetch against the model; miss reports whether a refill must follow.
   task automatic check_fetch(input logic [31:0] a, output bit miss);
      int idx, off;
      bit h;
      idx = int'((a >> 4) & 32'hF);
      off = int'((a >> 2) & 32'h3);
      h   = m_valid[idx] && (m_tag[idx] == (a >> 8));
      chk("stall", 32'(stall), h ? 32'd0 : 32'd1);
      chk("data", data, h ? m_data[idx][off] : 32'd0);
      miss = !h;
   endtask

   // Fetch one address, serving any refill bursts; gap = idle ack cycles before each ack.
   task automatic fetch(input logic [31:0] a, input int gap, input bit flush_last);
      int idx;
      logic [31:0] base;
      bit miss, fl;
      idx  = int'((a >> 4) & 32'hF);
      base = a & ~32'hF;
      fl   = flush_last;
      ce   = 1'b1;
      addr = a;
      #1;
      check_fetch(a, miss);
      for (int b = 0; b < 4 && miss; b++) begin
         m_valid[idx] = 1'b0;
         step();
         for (int w = 0; w < 4; w++) begin
            for (int g = 0; g < gap; g++) begin
               chk("req_gap", 32'(mem_req), 32'd1);
               chk("addr_gap", mem_addr, base + 32'(4 * w));
               step();
            end
            chk("req", 32'(mem_req), 32'd1);
            chk("mem_addr", mem_addr, base + 32'(4 * w));
            mem_ack  = 1'b1;
            mem_data = mem_rd(base + 32'(4 * w));
            m_data[idx][w] = mem_data;
            if (fl && w == 3) flush = 1'b1;
            step();
            mem_ack = 1'b0;
            flush   = 1'b0;
         end
         m_tag[idx] = a >> 8;
         if (fl) model_flush();
         else m_valid[idx] = 1'b1;
         fl = 1'b0;
         #1;
         chk("req_done", 32'(mem_req), 32'd0);
         check_fetch(a, miss);
      end
      step();
   endtask

   initial begin
      bit miss;
      logic [31:0] a;
      rst      = 1'b0;
      ce       = 1'b0;
      addr     = '0;
      flush    = 1'b0;
      mem_ack  = 1'b0;
      mem_data = '0;
      model_flush();
      #12;
      chk("rst_req", 32'(mem_req), 32'd0);
      chk("rst_addr", mem_addr, 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_data", data, 32'd0);
      rst = 1'b1;
      step();

      // 1: reset in the middle of a burst
      ce = 1'b1;
      addr = 32'h0;
      step();
      chk("t1_req", 32'(mem_req), 32'd1);
      #2 rst = 1'b0;
      #1;
      chk("t1_req_rst", 32'(mem_req), 32'd0);
      chk("t1_addr_rst", mem_addr, 32'd0);
      #1 rst = 1'b1;
      step();
      fetch(32'h0, 0, 1'b0);

      // 2: cold miss with known data, back-to-back acks
      for (int i = 0; i < 4; i++) ext_mem[32'h100 + 32'(4 * i)] = 32'hA0 + 32'(i);
      fetch(32'h100, 0, 1'b0);

      // 3: hits on the rest of the line
      fetch(32'h104, 0, 1'b0);
      fetch(32'h108, 0, 1'b0);
      fetch(32'h10C, 0, 1'b0);
      chk("t3_literal", m_data[0][3], 32'hA3);

      // 4: conflict on index 0, then re-miss of the original line
      fetch(32'h500, 0, 1'b0);
      fetch(32'h100, 0, 1'b0);

      // 5: ack every third cycle
      fetch(32'h300, 2, 1'b0);
      fetch(32'h304, 0, 1'b0);

      // 6: flush on the final ack forces a second burst
      fetch(32'h200, 0, 1'b1);
      ce = 1'b0;
      #1;
      chk("t6_ce0_data", data, 32'd0);
      chk("t6_ce0_stall", 32'(stall), 32'd0);
      step();

      // Randomized phase over a small address set to mix hits, conflicts and flushes.
      for (int k = 0; k < 60; k++) begin
         if ($urandom_range(0, 9) == 0) begin
            ce    = 1'b0;
            flush = 1'b1;
            #1;
            chk("rnd_flush_stall", 32'(stall), 32'd0);
            step();
            flush = 1'b0;
            model_flush();
         end else begin
            a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 4) |
                (32'($urandom_range(0, 3)) << 2);
            fetch(a, $urandom_range(0, 2), ($urandom_range(0, 7) == 0));
         end
      end

      ce = 1'b1;
      addr = 32'h100;
      #1;
      check_fetch(32'h100, miss);
      ce = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
